apb_uart_requester: RTL and testbench

- APB initiator that drives the APB UART slave from a simple command/response interface.
- Accepts one command at a time: config read, config write, TX write or RX read.
- Runs the two-phase APB SETUP/ACCESS handshake and waits on PREADY.
- Returns read data and error status on a response channel.
- Sits between the system command source (CPU stub or test sequencer) and the UART's APB port; also used as the reusable bus driver in the UVM harness.

---
 rtl/apb_uart_requester.sv | 118 +++++++++++
 tb/tb_apb_uart_requester.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_uart_requester.sv
// APB initiator for the UART slave: takes one command at a time, runs SETUP/ACCESS
// against the UART's APB port, and returns read data and error status as a held response.
module apb_uart_requester #(
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TO_WIDTH       = 11
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_error,
  output logic                  rsp_timeout,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR
);

  // state  | meaning
  // IDLE   | waiting for a command; cmd_ready high (from one cycle after reset)
  // SETUP  | APB setup phase, PSEL=1 PENABLE=0, always one cycle
  // ACCESS | APB access phase, waiting on PREADY or the timeout
  // RESP   | response held on rsp_* until rsp_ready
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_RESP
  } state_t;

  localparam bit                TO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [TO_WIDTH-1:0] TO_LAST = TO_WIDTH'(TIMEOUT_CYCLES - 1);

  state_t              state;
  logic [TO_WIDTH-1:0] to_cnt;

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state       <= ST_IDLE;
      to_cnt      <= '0;
      cmd_ready   <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_error   <= 1'b0;
      rsp_timeout <= 1'b0;
      PSEL        <= 1'b0;
      PENABLE     <= 1'b0;
      PWRITE      <= 1'b0;
      PADDR       <= '0;
      PWDATA      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          // cmd_ready is only low here on the first cycle out of reset
          if (!cmd_ready) begin
            cmd_ready <= 1'b1;
          end else if (cmd_valid) begin
            PWRITE    <= cmd_write;
            PADDR     <= cmd_addr;
            PWDATA    <= cmd_wdata;
            cmd_ready <= 1'b0;
            PSEL      <= 1'b1;
            state     <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          PENABLE <= 1'b1;
          state   <= ST_ACCESS;
        end
        ST_ACCESS: begin
          // PREADY takes priority over a timeout landing on the same cycle
          if (PREADY) begin
            rsp_rdata   <= PWRITE ? '0 : PRDATA;
            rsp_error   <= PSLVERR;
            rsp_timeout <= 1'b0;
            rsp_valid   <= 1'b1;
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
            to_cnt      <= '0;
            state       <= ST_RESP;
          end else if (TO_EN && (to_cnt == TO_LAST)) begin
            rsp_rdata   <= '0;
            rsp_error   <= 1'b1;
            rsp_timeout <= 1'b1;
            rsp_valid   <= 1'b1;
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
            to_cnt      <= '0;
            state       <= ST_RESP;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_uart_requester.sv
// Self-checking bench for apb_uart_requester: the bench plays the APB slave and the
// command/response master, and predicts each transfer from wait count, data and error inputs.
module tb_apb_uart_requester;

  localparam int AW  = 8;
  localparam int DW  = 32;
  localparam int TO  = 16;
  localparam int TOW = 5;
  localparam logic [AW-1:0] BAUD_ADDR  = 8'h04;
  localparam logic [AW-1:0] FRAME_ADDR = 8'h08;

  logic          PCLK;
  logic          PRESET;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_error;
  logic          rsp_timeout;
  logic          PSEL;
  logic          PENABLE;
  logic          PWRITE;
  logic [AW-1:0] PADDR;
  logic [DW-1:0] PWDATA;
  logic [DW-1:0] PRDATA;
  logic          PREADY;
  logic          PSLVERR;

  apb_uart_requester #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO), .TO_WIDTH(TOW)
  ) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_error(rsp_error), .rsp_timeout(rsp_timeout),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  int cyc = 0;
  always @(posedge PCLK) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  // Expected outcome of one transfer, derived from how long the slave stalls
  typedef struct {
    int            pen;
    int            psel;
    int            lat;
    logic [DW-1:0] rdata;
    logic          err;
    logic          tmo;
  } exp_t;

  function automatic exp_t model(input logic wr, input int wait_n,
                                 input logic [DW-1:0] rdata, input logic slverr);
    exp_t e;
    e.tmo   = (wait_n >= TO);
    e.pen   = e.tmo ? TO : wait_n + 1;
    e.psel  = e.pen + 1;
    e.lat   = e.pen + 2;
    e.rdata = (e.tmo || wr) ? '0 : rdata;
    e.err   = e.tmo | slverr;
    return e;
  endfunction

  int            o_acc_cyc, o_rsp_cyc, o_hs_cyc, o_psel, o_pen;
  bit            o_bus_ok, o_cr_ok, o_bp_ok, o_done;
  logic [DW-1:0] o_rdata;
  logic          o_err, o_to;

  // Drives one command and plays the slave; called right after a falling edge
  task automatic xfer(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                      input int wait_n, input logic [DW-1:0] rdata, input logic slverr,
                      input logic glitch, input int rsp_hold);
    int acc_i;
    int hold;
    int budget;
    bit seen;
    o_psel = 0; o_pen = 0; o_bus_ok = 1; o_cr_ok = 1; o_bp_ok = 1; o_done = 0;
    o_rdata = '0; o_err = 1'b0; o_to = 1'b0; o_rsp_cyc = 0; o_hs_cyc = 0;
    seen = 0; acc_i = 0; hold = 0; budget = 0;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata;
    while (!cmd_ready && budget < 20) begin
      @(negedge PCLK);
      budget++;
    end
    if (!cmd_ready) begin
      tests++; fails++;
      $display("FAIL accept_wait: cmd_ready=%0b required 1 within 20 cycles", cmd_ready);
      cmd_valid = 1'b0;
      return;
    end
    o_acc_cyc = cyc;
    for (int i = 0; i < 100 && !o_done; i++) begin
      @(negedge PCLK);
      cmd_write = 1'($urandom_range(1)); cmd_addr = AW'($urandom); cmd_wdata = $urandom;
      if (cmd_ready) o_cr_ok = 0;
      if (PSEL) begin
        o_psel++;
        if (PADDR !== addr || PWRITE !== wr || PWDATA !== wdata) o_bus_ok = 0;
      end
      if (PENABLE) o_pen++;
      if (PSEL && PENABLE) begin
        acc_i++;
        PREADY  = (acc_i > wait_n);
        PRDATA  = PREADY ? rdata : $urandom;
        PSLVERR = PREADY ? slverr : glitch;
      end else begin
        PREADY = 1'b0; PRDATA = $urandom; PSLVERR = 1'b0;
      end
      if (rsp_valid) begin
        if (!seen) begin
          seen = 1; o_rsp_cyc = cyc;
          o_rdata = rsp_rdata; o_err = rsp_error; o_to = rsp_timeout;
        end else if (rsp_rdata !== o_rdata || rsp_error !== o_err || rsp_timeout !== o_to) begin
          o_bp_ok = 0;
        end
        if (hold < rsp_hold) begin
          rsp_ready = 1'b0; hold++;
        end else begin
          rsp_ready = 1'b1; cmd_valid = 1'b0; o_hs_cyc = cyc; o_done = 1;
        end
      end
    end
    if (!o_done) begin
      tests++; fails++;
      $display("FAIL xfer_budget: no response handshake within 100 cycles (psel=%0d pen=%0d)", o_psel, o_pen);
      cmd_valid = 1'b0;
    end
  endtask

  task automatic test_reset();
    PRESET = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b0; PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;
    #2;
    tests++;
    if ({PSEL, PENABLE, PWRITE, PADDR, PWDATA} !== '0) begin
      fails++; $display("FAIL reset_bus: got %0b/%0b/%0b/%h/%h required all 0", PSEL, PENABLE, PWRITE, PADDR, PWDATA);
    end
    tests++;
    if ({cmd_ready, rsp_valid, rsp_error, rsp_timeout, rsp_rdata} !== '0) begin
      fails++; $display("FAIL reset_rsp: got cr=%0b rv=%0b re=%0b rt=%0b rd=%h required all 0",
                        cmd_ready, rsp_valid, rsp_error, rsp_timeout, rsp_rdata);
    end
    repeat (3) @(negedge PCLK);
    PRESET = 1'b0;
    @(negedge PCLK);
    tests++;
    if (cmd_ready !== 1'b1) begin
      fails++; $display("FAIL reset_cmd_ready: got %0b required 1 one cycle after release", cmd_ready);
    end
  endtask

  task automatic test_baud_write();
    xfer(1'b1, BAUD_ADDR, 32'd115200, 0, 32'hDEAD_BEEF, 1'b0, 1'b0, 0);
    tests++; if (o_psel !== 2) begin fails++; $display("FAIL baud_psel_cycles: got %0d required 2", o_psel); end
    tests++; if (o_pen !== 1) begin fails++; $display("FAIL baud_penable_cycles: got %0d required 1", o_pen); end
    tests++; if (o_rsp_cyc - o_acc_cyc !== 3) begin fails++; $display("FAIL baud_latency: got %0d required 3", o_rsp_cyc - o_acc_cyc); end
    tests++; if (o_err !== 1'b0 || o_rdata !== '0) begin fails++; $display("FAIL baud_rsp: got err=%0b rdata=%h required 0/0", o_err, o_rdata); end
    tests++; if (!o_bus_ok) begin fails++; $display("FAIL baud_bus: got unstable or wrong PADDR/PWRITE/PWDATA required addr %h data 115200", BAUD_ADDR); end
  endtask

  task automatic test_frame_read();
    xfer(1'b0, FRAME_ADDR, $urandom, 3, 32'd8, 1'b0, 1'b0, 0);
    tests++; if (o_pen !== 4) begin fails++; $display("FAIL frame_penable_cycles: got %0d required 4", o_pen); end
    tests++; if (!o_bus_ok) begin fails++; $display("FAIL frame_paddr_stable: got unstable bus required %h throughout", FRAME_ADDR); end
    tests++; if (o_rdata !== 32'd8 || o_err !== 1'b0) begin fails++; $display("FAIL frame_rsp: got rdata=%0d err=%0b required 8/0", o_rdata, o_err); end
  endtask

  task automatic test_slverr();
    xfer(1'b1, BAUD_ADDR, $urandom, 2, $urandom, 1'b1, 1'b0, 0);
    tests++; if (o_err !== 1'b1 || o_to !== 1'b0) begin fails++; $display("FAIL slverr_write: got err=%0b to=%0b required 1/0", o_err, o_to); end
    xfer(1'b0, FRAME_ADDR, $urandom, 3, 32'h0000_00A5, 1'b0, 1'b1, 0);
    tests++; if (o_err !== 1'b0 || o_rdata !== 32'h0000_00A5) begin fails++; $display("FAIL slverr_glitch_ignored: got err=%0b rdata=%h required 0/a5", o_err, o_rdata); end
  endtask

  task automatic test_timeout();
    xfer(1'b0, FRAME_ADDR, $urandom, 60, 32'h1234_5678, 1'b0, 1'b0, 0);
    tests++; if (o_pen !== TO || o_psel !== TO + 1) begin fails++; $display("FAIL timeout_len: got pen=%0d psel=%0d required %0d/%0d", o_pen, o_psel, TO, TO + 1); end
    tests++; if (o_err !== 1'b1 || o_to !== 1'b1 || o_rdata !== '0) begin fails++; $display("FAIL timeout_rsp: got err=%0b to=%0b rdata=%h required 1/1/0", o_err, o_to, o_rdata); end
    xfer(1'b0, FRAME_ADDR, $urandom, TO - 1, 32'h1234_5678, 1'b0, 1'b0, 0);
    tests++; if (o_pen !== TO) begin fails++; $display("FAIL timeout_edge_len: got pen=%0d required %0d", o_pen, TO); end
    tests++; if (o_err !== 1'b0 || o_to !== 1'b0 || o_rdata !== 32'h1234_5678) begin fails++; $display("FAIL timeout_edge_rsp: got err=%0b to=%0b rdata=%h required 0/0/12345678", o_err, o_to, o_rdata); end
  endtask

  task automatic test_back_to_back();
    int hs;
    logic [AW-1:0] a2;
    xfer(1'b0, BAUD_ADDR, $urandom, 1, 32'h0001_C200, 1'b0, 1'b0, 5);
    hs = o_hs_cyc;
    tests++; if (!o_bp_ok || o_rdata !== 32'h0001_C200) begin fails++; $display("FAIL bp_rsp_stable: got stable=%0b rdata=%h required 1/1c200", o_bp_ok, o_rdata); end
    tests++; if (!o_cr_ok) begin fails++; $display("FAIL bp_cmd_ready: got cmd_ready=1 during transfer required 0"); end
    a2 = AW'($urandom);
    xfer(1'b1, a2, $urandom, 0, $urandom, 1'b0, 1'b0, 0);
    tests++; if (o_acc_cyc !== hs + 1) begin fails++; $display("FAIL b2b_accept: got cycle %0d required %0d", o_acc_cyc, hs + 1); end
    tests++; if (PADDR !== a2) begin fails++; $display("FAIL paddr_retain: got %h required %h", PADDR, a2); end
  endtask

  task automatic test_reset_mid();
    bit spurious;
    int budget;
    exp_t e;
    spurious = 0; budget = 0;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = FRAME_ADDR; cmd_wdata = $urandom;
    while (!cmd_ready && budget < 20) begin @(negedge PCLK); budget++; end
    repeat (4) @(negedge PCLK);
    cmd_valid = 1'b0; PREADY = 1'b0;
    #2 PRESET = 1'b1;
    #1;
    tests++;
    if ({PSEL, PENABLE, rsp_valid} !== 3'b000) begin
      fails++; $display("FAIL reset_mid_bus: got psel=%0b pen=%0b rv=%0b required 0/0/0", PSEL, PENABLE, rsp_valid);
    end
    @(negedge PCLK);
    PRESET = 1'b0; PREADY = 1'b1; PRDATA = $urandom;
    for (int i = 0; i < 8; i++) begin
      @(negedge PCLK);
      if (rsp_valid || PSEL) spurious = 1;
    end
    PREADY = 1'b0;
    tests++; if (spurious) begin fails++; $display("FAIL reset_mid_no_rsp: got activity after release required none"); end
    e = model(1'b0, 2, 32'h0000_0077, 1'b0);
    xfer(1'b0, FRAME_ADDR, $urandom, 2, 32'h0000_0077, 1'b0, 1'b0, 0);
    tests++;
    if (o_rdata !== e.rdata || o_rsp_cyc - o_acc_cyc !== e.lat) begin
      fails++; $display("FAIL reset_mid_recover: got rdata=%h lat=%0d required %h/%0d", o_rdata, o_rsp_cyc - o_acc_cyc, e.rdata, e.lat);
    end
  endtask

  task automatic test_random();
    logic          wr, se, gl;
    logic [AW-1:0] ad;
    logic [DW-1:0] wd, rd;
    int            wn, rh;
    exp_t          e;
    for (int n = 0; n < 24; n++) begin
      wr = 1'($urandom_range(1)); se = 1'($urandom_range(1)); gl = 1'($urandom_range(1));
      ad = AW'($urandom); wd = $urandom; rd = $urandom;
      wn = $urandom_range(20); rh = $urandom_range(3);
      e = model(wr, wn, rd, se);
      xfer(wr, ad, wd, wn, rd, se, gl, rh);
      tests++;
      if (o_pen !== e.pen || o_psel !== e.psel || o_rsp_cyc - o_acc_cyc !== e.lat) begin
        fails++; $display("FAIL rand%0d_timing: got pen=%0d psel=%0d lat=%0d required %0d/%0d/%0d",
                          n, o_pen, o_psel, o_rsp_cyc - o_acc_cyc, e.pen, e.psel, e.lat);
      end
      tests++;
      if (o_rdata !== e.rdata || o_err !== e.err || o_to !== e.tmo) begin
        fails++; $display("FAIL rand%0d_rsp: got rdata=%h err=%0b to=%0b required %h/%0b/%0b",
                          n, o_rdata, o_err, o_to, e.rdata, e.err, e.tmo);
      end
      tests++;
      if (!o_bus_ok || !o_bp_ok || !o_cr_ok) begin
        fails++; $display("FAIL rand%0d_stability: got bus=%0b rsp=%0b cmd_ready_low=%0b required 1/1/1",
                          n, o_bus_ok, o_bp_ok, o_cr_ok);
      end
    end
  endtask

  initial begin
    test_reset();
    test_baud_write();
    test_frame_read();
    test_slverr();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    test_random();
    repeat (2) @(negedge PCLK);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at 500000 time units required finished");
    $fatal(1);
  end

endmodule
